// File: rtl/multiplayer_link_if.sv
// Link bundle for multiplayer_link: local controls, the link connector (tx/rx)
// and the filtered remote view. The slave modport is the link block itself.
interface multiplayer_link_if #(
  parameter int N_REMOTE = 1,
  parameter int SCORE_W  = 4
);
  localparam int LEAD_W = ($clog2(N_REMOTE + 1) > 1) ? $clog2(N_REMOTE + 1) : 1;

  logic                          local_pause;
  logic                          local_reload;
  logic [SCORE_W-1:0]            local_score;
  logic                          tx_pause;
  logic                          tx_reload;
  logic [SCORE_W-1:0]            tx_score;
  logic [N_REMOTE-1:0]           rx_pause_raw;
  logic [N_REMOTE-1:0]           rx_reload_raw;
  logic [N_REMOTE*SCORE_W-1:0]   rx_score_raw;
  logic [N_REMOTE-1:0]           remote_pause;
  logic [N_REMOTE-1:0]           remote_reload_pulse;
  logic [N_REMOTE*SCORE_W-1:0]   remote_score;
  logic [N_REMOTE-1:0]           remote_score_upd;
  logic                          game_pause;
  logic [LEAD_W-1:0]             leader;

  modport slave (
    input  local_pause, local_reload, local_score,
    input  rx_pause_raw, rx_reload_raw, rx_score_raw,
    output tx_pause, tx_reload, tx_score,
    output remote_pause, remote_reload_pulse, remote_score, remote_score_upd,
    output game_pause, leader
  );

  modport master (
    output local_pause, local_reload, local_score,
    output rx_pause_raw, rx_reload_raw, rx_score_raw,
    input  tx_pause, tx_reload, tx_score,
    input  remote_pause, remote_reload_pulse, remote_score, remote_score_upd,
    input  game_pause, leader
  );
endinterface

// File: rtl/multiplayer_link.sv
// Multiplayer link: forwards local state to the connector and glitch-filters
// every remote field, deriving reload/score-update pulses, global pause and leader.
module multiplayer_link #(
  parameter int N_REMOTE      = 1,
  parameter int SCORE_W       = 4,
  parameter int STABLE_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  multiplayer_link_if.slave   lnk
);
  localparam int LEAD_W = ($clog2(N_REMOTE + 1) > 1) ? $clog2(N_REMOTE + 1) : 1;
  localparam int NL     = 2 * N_REMOTE;
  localparam int CNT_W  = 16;
  localparam logic [CNT_W-1:0] STABLE_V = CNT_W'(STABLE_CYCLES);

  // Level fields: bits [N_REMOTE-1:0] are pause, [NL-1:N_REMOTE] are reload.
  logic [NL-1:0]       lvl_s1_q, lvl_s1_d;
  logic [NL-1:0]       lvl_s2_q, lvl_s2_d;
  logic [NL-1:0]       lvl_prev_q, lvl_prev_d;
  logic [NL-1:0]       lvl_acc_q, lvl_acc_d;
  logic [CNT_W-1:0]    lvl_cnt_q [NL];
  logic [CNT_W-1:0]    lvl_cnt_d [NL];

  logic [SCORE_W-1:0]  sc_s1_q   [N_REMOTE];
  logic [SCORE_W-1:0]  sc_s1_d   [N_REMOTE];
  logic [SCORE_W-1:0]  sc_s2_q   [N_REMOTE];
  logic [SCORE_W-1:0]  sc_s2_d   [N_REMOTE];
  logic [SCORE_W-1:0]  sc_prev_q [N_REMOTE];
  logic [SCORE_W-1:0]  sc_prev_d [N_REMOTE];
  logic [SCORE_W-1:0]  sc_acc_q  [N_REMOTE];
  logic [SCORE_W-1:0]  sc_acc_d  [N_REMOTE];
  logic [CNT_W-1:0]    sc_cnt_q  [N_REMOTE];
  logic [CNT_W-1:0]    sc_cnt_d  [N_REMOTE];
  logic [N_REMOTE-1:0] sc_upd_q, sc_upd_d;

  logic [N_REMOTE-1:0] rl_dly_q, rl_dly_d;
  logic [N_REMOTE-1:0] rl_pulse_q, rl_pulse_d;

  logic                tx_pause_q, tx_pause_d;
  logic                tx_reload_q, tx_reload_d;
  logic [SCORE_W-1:0]  tx_score_q, tx_score_d;
  logic                game_pause_q, game_pause_d;
  logic [LEAD_W-1:0]   leader_q, leader_d;
  logic [SCORE_W-1:0]  leader_best;
  logic [N_REMOTE*SCORE_W-1:0] remote_score_flat;

  always_comb begin
    lvl_s1_d   = {lnk.rx_reload_raw, lnk.rx_pause_raw};
    lvl_s2_d   = lvl_s1_q;
    lvl_prev_d = lvl_s2_q;
    lvl_acc_d  = lvl_acc_q;
    // Counter restarts on any synchronized change; value is taken when it hits the limit.
    for (int i = 0; i < NL; i++) begin
      if (lvl_s2_q[i] != lvl_prev_q[i])
        lvl_cnt_d[i] = '0;
      else if (lvl_cnt_q[i] == STABLE_V)
        lvl_cnt_d[i] = lvl_cnt_q[i];
      else
        lvl_cnt_d[i] = lvl_cnt_q[i] + 1'b1;
      if (lvl_cnt_d[i] == STABLE_V)
        lvl_acc_d[i] = lvl_s2_q[i];
    end

    sc_upd_d = '0;
    for (int k = 0; k < N_REMOTE; k++) begin
      sc_s1_d[k]   = lnk.rx_score_raw[k*SCORE_W +: SCORE_W];
      sc_s2_d[k]   = sc_s1_q[k];
      sc_prev_d[k] = sc_s2_q[k];
      sc_acc_d[k]  = sc_acc_q[k];
      if (sc_s2_q[k] != sc_prev_q[k])
        sc_cnt_d[k] = '0;
      else if (sc_cnt_q[k] == STABLE_V)
        sc_cnt_d[k] = sc_cnt_q[k];
      else
        sc_cnt_d[k] = sc_cnt_q[k] + 1'b1;
      // The limit is held while saturated, so equal re-loads must not flag an update.
      if (sc_cnt_d[k] == STABLE_V) begin
        sc_acc_d[k] = sc_s2_q[k];
        sc_upd_d[k] = (sc_s2_q[k] != sc_acc_q[k]);
      end
    end

    rl_dly_d   = lvl_acc_q[NL-1:N_REMOTE];
    rl_pulse_d = lvl_acc_q[NL-1:N_REMOTE] & ~rl_dly_q;

    tx_pause_d   = lnk.local_pause;
    tx_reload_d  = lnk.local_reload;
    tx_score_d   = lnk.local_score;
    game_pause_d = tx_pause_q | (|lvl_acc_q[N_REMOTE-1:0]);

    // Strict greater-than keeps the lowest index on ties.
    leader_best = tx_score_q;
    leader_d    = '0;
    for (int k = 0; k < N_REMOTE; k++) begin
      if (sc_acc_q[k] > leader_best) begin
        leader_best = sc_acc_q[k];
        leader_d    = LEAD_W'(k + 1);
      end
    end

    remote_score_flat = '0;
    for (int k = 0; k < N_REMOTE; k++)
      remote_score_flat[k*SCORE_W +: SCORE_W] = sc_acc_q[k];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl_s1_q     <= '0;
      lvl_s2_q     <= '0;
      lvl_prev_q   <= '0;
      lvl_acc_q    <= '0;
      lvl_cnt_q    <= '{default: '0};
      sc_s1_q      <= '{default: '0};
      sc_s2_q      <= '{default: '0};
      sc_prev_q    <= '{default: '0};
      sc_acc_q     <= '{default: '0};
      sc_cnt_q     <= '{default: '0};
      sc_upd_q     <= '0;
      rl_dly_q     <= '0;
      rl_pulse_q   <= '0;
      tx_pause_q   <= 1'b0;
      tx_reload_q  <= 1'b0;
      tx_score_q   <= '0;
      game_pause_q <= 1'b0;
      leader_q     <= '0;
    end else begin
      lvl_s1_q     <= lvl_s1_d;
      lvl_s2_q     <= lvl_s2_d;
      lvl_prev_q   <= lvl_prev_d;
      lvl_acc_q    <= lvl_acc_d;
      lvl_cnt_q    <= lvl_cnt_d;
      sc_s1_q      <= sc_s1_d;
      sc_s2_q      <= sc_s2_d;
      sc_prev_q    <= sc_prev_d;
      sc_acc_q     <= sc_acc_d;
      sc_cnt_q     <= sc_cnt_d;
      sc_upd_q     <= sc_upd_d;
      rl_dly_q     <= rl_dly_d;
      rl_pulse_q   <= rl_pulse_d;
      tx_pause_q   <= tx_pause_d;
      tx_reload_q  <= tx_reload_d;
      tx_score_q   <= tx_score_d;
      game_pause_q <= game_pause_d;
      leader_q     <= leader_d;
    end
  end

  assign lnk.tx_pause            = tx_pause_q;
  assign lnk.tx_reload           = tx_reload_q;
  assign lnk.tx_score            = tx_score_q;
  assign lnk.remote_pause        = lvl_acc_q[N_REMOTE-1:0];
  assign lnk.remote_reload_pulse = rl_pulse_q;
  assign lnk.remote_score        = remote_score_flat;
  assign lnk.remote_score_upd    = sc_upd_q;
  assign lnk.game_pause          = game_pause_q;
  assign lnk.leader              = leader_q;
endmodule

// File: doc/multiplayer_link.md
MULTIPLAYER_LINK -- requirements
Module: multiplayer_link

Interface
REQ-001 SHALL have parameter N_REMOTE, default 1: number of remote player boards, legal range 1..4.
REQ-002 SHALL have parameter SCORE_W, default 4: score field width in bits, legal range 1..8.
REQ-003 SHALL have parameter STABLE_CYCLES, default 16: glitch-filter length in clk cycles, legal range 2..65535.
REQ-004 SHALL define LEAD_W = max(1, clog2(N_REMOTE+1)) as a derived localparam.
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 local_pause  in  1  local pause level, synchronous to clk.
REQ-008 local_reload  in  1  local reload level, synchronous to clk.
REQ-009 local_score  in  SCORE_W  local score, synchronous to clk.
REQ-010 tx_pause, tx_reload  out  1 each  registered copies of the local_pause and local_reload levels, driven to the link connector.
REQ-011 tx_score  out  SCORE_W  registered copy of local_score.
REQ-012 rx_pause_raw, rx_reload_raw  in  N_REMOTE each  asynchronous remote levels, one bit per channel.
REQ-013 rx_score_raw  in  N_REMOTE*SCORE_W  asynchronous remote scores; channel k occupies bits [k*SCORE_W +: SCORE_W].
REQ-014 remote_pause  out  N_REMOTE  filtered remote pause levels.
REQ-015 remote_reload_pulse  out  N_REMOTE  one-cycle pulse on each accepted reload rising edge.
REQ-016 remote_score  out  N_REMOTE*SCORE_W  filtered remote scores, packed the same way as rx_score_raw.
REQ-017 remote_score_upd  out  N_REMOTE  one-cycle pulse when a channel's accepted score changes.
REQ-018 game_pause  out  1  global pause.
REQ-019 leader  out  LEAD_W  index of the highest score: 0 = local, k+1 = remote channel k.

Function
REQ-020 Every raw rx bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-021 Filter SHALL be per channel and per field (pause, reload, whole score); each filter has its own counter, at least 16 bits wide, that saturates at STABLE_CYCLES.
REQ-022 Filter counter SHALL clear on any cycle in which its synchronized field differs from the previous cycle's value, including a change in any single score bit, and SHALL increment otherwise.
REQ-023 Accepted value SHALL load the synchronized field on the cycle the counter reaches STABLE_CYCLES.
REQ-024 Latency: a raw change held stable SHALL appear on remote_pause/remote_score exactly STABLE_CYCLES+3 clk edges after the first edge that samples it.
REQ-025 Glitch rejection: a raw pulse shorter than STABLE_CYCLES cycles SHALL never change any accepted value or output.
REQ-026 remote_reload_pulse[k] SHALL assert for exactly one cycle, on the cycle after accepted reload k rises 0->1; it SHALL NOT pulse on a 1->0 transition.
REQ-027 remote_score_upd[k] SHALL assert for exactly one cycle, on the cycle remote_score[k] takes a new value differing from its old value; re-accepting an equal value SHALL NOT pulse.
REQ-028 tx_pause, tx_reload and tx_score SHALL lag their local inputs by exactly 1 cycle.
REQ-029 game_pause SHALL be registered: tx_pause OR any remote_pause bit, with 1 cycle of latency after those signals.
REQ-030 leader SHALL be registered and SHALL be recomputed every cycle from tx_score and the remote_score fields.
REQ-031 leader comparison SHALL be unsigned.
REQ-032 leader tie-break SHALL select the lowest index, so local wins all ties.
REQ-033 Channels SHALL be fully independent; simultaneous events on several channels SHALL each produce their own pulses in the same cycle.
REQ-034 Simultaneous pause and reload changes on one channel SHALL be filtered independently.

Reset
REQ-035 On rst_n low, asynchronously: synchronizers, counters, accepted values and all outputs SHALL be 0 (leader = 0).
REQ-036 Reset SHALL take effect mid-filter, aborting any in-progress acceptance.
REQ-037 After rst_n rises, no pulse SHALL occur for a remote whose raw level is 0.
REQ-038 After rst_n rises, a remote whose raw level is 1 SHALL be treated as a fresh 0->1 edge: it is accepted after the full latency and SHALL produce one reload pulse.

Verification
REQ-039 N_REMOTE=2, STABLE_CYCLES=16; rx_pause_raw[1] 0->1 held -> remote_pause[1]=1 at edge 19; game_pause=1 at edge 20; channel 0 unchanged.
REQ-040 rx_reload_raw[0] high for 15 cycles, then low -> no remote_reload_pulse; held 40 cycles -> exactly one 1-cycle pulse.
REQ-041 rx_score_raw ch0 3->5 with one bit glitching back at cycle 8 -> remote_score[0] becomes 5 only 19 edges after the glitch ends; remote_score_upd[0] pulses once.
REQ-042 local_score=7, remote scores 7 and 9 -> leader=2; remote 9->7 -> leader=0 (tie, local wins).
REQ-043 rst_n asserted at cycle 10 of a 16-cycle acceptance -> all outputs 0 immediately; after release, full 19-edge latency restarts.
